// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default constants for the register write arbiter.
package reg_write_arbiter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    // Requester indices are carried in 3 bits, enough for up to 8 requesters.
    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage : reg_write_arbiter_pkg

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin select: first set request found searching
// upward from ptr+1 with wrap-around.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic [N_REQ-1:0] winner,
    output idx_t             winner_idx,
    output logic             found
);

    int               start;
    int               pos;
    logic [N_REQ-1:0] rot;

    // Rotate req so bit 0 is requester ptr+1, then take the lowest set bit.
    // NOTE: every variable assigned in this block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        start      = int'(ptr) + 1;
        if (start >= N_REQ) start = 0;
        rot        = (req >> start) | (req << (N_REQ - start));
        found      = 1'b0;
        pos        = 0;
        winner_idx = '0;
        winner     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = start + i;
                if (pos >= N_REQ) pos = pos - N_REQ;
                winner_idx = idx_t'(pos);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            winner[i] = found && (idx_t'(i) == winner_idx);
        end
    end

endmodule : rr_pick

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared
// register. Each write takes IDLE (grant) -> WRITE (load) -> ACK (pulse).
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [2:0]             owner,
    output logic [7:0]             wr_cnt,
    output logic                   busy
);

    state_t           state, state_next;
    logic [N_REQ-1:0] gnt_next, ack_next;
    idx_t             win_idx, win_idx_next;
    idx_t             ptr;
    logic             write_en;
    logic [WIDTH-1:0] wdata_sel;

    logic [N_REQ-1:0] pick_onehot;
    idx_t             pick_idx;
    logic             pick_found;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    // Select the granted requester's data slice; gnt stays one-hot in WRITE.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) wdata_sel = wdata[i*WIDTH +: WIDTH];
        end
    end

    // Next-state, grant and ack decode.
    always_comb begin
        state_next   = state;
        gnt_next     = '0;
        ack_next     = '0;
        win_idx_next = win_idx;
        write_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_next     = pick_onehot;
                    win_idx_next = pick_idx;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                // A winner that dropped its request forfeits the slot.
                if (|(req & gnt)) begin
                    write_en   = 1'b1;
                    ack_next   = gnt;
                    state_next = ACK;
                end else begin
                    state_next = IDLE;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state, registered grant/ack and winner index.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            win_idx <= '0;
        end else begin
            state   <= state_next;
            gnt     <= gnt_next;
            ack     <= ack_next;
            win_idx <= win_idx_next;
        end
    end

    // Shared register and write bookkeeping, updated only by a completed write.
    // NOTE: q is a plain data register, but it is reset because its post-reset value of zero is architecturally visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            owner  <= '0;
            ptr    <= idx_t'(N_REQ - 1);
            wr_cnt <= '0;
        end else if (write_en) begin
            q      <= wdata_sel;
            owner  <= win_idx;
            ptr    <= win_idx;
            wr_cnt <= wr_cnt + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule : reg_write_arbiter
